// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types, default sizing and the wrapping first-set search used by the
// round-robin decode arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;

    // Widest request vector the search helper handles (WIDTH up to 8).
    localparam int unsigned MAX_REQ = 256;

    // Index of the first set bit at or after 'start', wrapping modulo
    // (mask+1). mask must be 2**WIDTH-1. Returns 'start' when vec is empty;
    // callers only use the result when some request is set.
    function automatic logic [7:0] first_set_wrap(
        input logic [MAX_REQ-1:0] vec,
        input logic [7:0]         start,
        input logic [7:0]         mask
    );
        logic [7:0] idx;
        logic       found;
        first_set_wrap = start;
        found          = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (start + 8'(i)) & mask;
            if (!found && vec[idx]) begin
                first_set_wrap = idx;
                found          = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_decode_shift.sv
// Binary-to-one-hot decoder for the grant index.
module decode_shift
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]      idx,
    output logic [2**WIDTH-1:0]   onehot
);

    // Exactly one select line high, chosen by idx.
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter: one registered owner index at a time, held until the
// owner finishes, drops its request, or exceeds MAX_HOLD cycles.
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2**WIDTH-1:0]  req,
    input  logic                 done,
    output logic                 grant_valid,
    output logic [WIDTH-1:0]     grant_idx,
    output logic [2**WIDTH-1:0]  grant_oh,
    output logic                 timeout
);

    localparam int unsigned N     = 2**WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic             grant_valid_q, grant_valid_d;
    logic [WIDTH-1:0] grant_idx_q, grant_idx_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] first_idx;
    logic             rel_drop;
    logic             rel_hold;
    logic [N-1:0]     oh_raw;

    // Next owner candidate: first requester at or after the pointer.
    assign first_idx = WIDTH'(first_set_wrap(MAX_REQ'(req), 8'(ptr_q), 8'(N - 1)));

    // Release causes while a grant is held.
    assign rel_drop = ~req[grant_idx_q];
    assign rel_hold = (cnt_q == CNT_LAST);

    // Next-state and registered-output logic for the IDLE/GRANT sequencer.
    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_idx_d   = first_idx;
                    grant_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                if (done || rel_drop || rel_hold) begin
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                    ptr_d         = grant_idx_q + WIDTH'(1);
                    // A forced release only reports when nothing else ended the grant.
                    timeout_d     = rel_hold & ~done & ~rel_drop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d       = IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
        end
    end

    decode_shift #(
        .WIDTH (WIDTH)
    ) u_decode_shift (
        .idx    (grant_idx_q),
        .onehot (oh_raw)
    );

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign grant_oh    = grant_valid_q ? oh_raw : '0;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed and randomized bench for rr_decode_arbiter (WIDTH=4, MAX_HOLD=8).
module tb_rr_decode_arbiter;

    localparam int WIDTH    = 4;
    localparam int N        = 16;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic             done;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_idx;
    logic [N-1:0]     grant_oh;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: owner number, cycles it has been visible, next-start pointer.
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_decode_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_oh    (grant_oh),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_step();
        bit drop;
        bit forced;
        int c;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (!m_valid) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (req[c]) begin
                        m_idx   = c;
                        m_valid = 1'b1;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else begin
            drop   = !req[m_idx];
            forced = (m_held == MAX_HOLD);
            if (done || drop || forced) begin
                m_valid = 1'b0;
                m_ptr   = (m_idx + 1) % N;
                m_to    = forced && !done && !drop;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all();
        chk("grant_valid", 32'(grant_valid), 32'(m_valid));
        chk("grant_idx", 32'(grant_idx), 32'(m_idx));
        chk("grant_oh", 32'(grant_oh), m_valid ? (32'd1 << m_idx) : 32'd0);
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '1;
        done  = 1'b0;

        // Reset held for three cycles with every requester active.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", 32'(grant_valid), 32'd0);
            chk("rst_oh", 32'(grant_oh), 32'd0);
            chk("rst_timeout", 32'(timeout), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("first_idx", 32'(grant_idx), 32'd0);
        chk("first_oh", 32'(grant_oh), 32'h0001);

        // Strict rotation with done on the second grant cycle.
        for (int g = 0; g < 17; g++) begin
            chk("rot_idx", 32'(grant_idx), 32'(g % N));
            chk("rot_valid", 32'(grant_valid), 32'd1);
            done = 1'b0;
            tick();
            done = 1'b1;
            tick();
            chk("rot_gap", 32'(grant_valid), 32'd0);
            done = 1'b0;
            tick();
        end

        // Pointer skip and wrap.
        req  = 16'h0008;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("skip_idx3", 32'(grant_idx), 32'd3);
        req = 16'h0005;
        tick();
        tick();
        chk("skip_wrap0", 32'(grant_idx), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("skip_idx2", 32'(grant_idx), 32'd2);
        done = 1'b1;
        tick();
        done = 1'b0;

        // Hold timeout on a lone requester.
        req = 16'h0010;
        tick();
        chk("to_idx", 32'(grant_idx), 32'd4);
        for (int i = 1; i < MAX_HOLD; i++) begin
            tick();
            chk("to_held", 32'(grant_valid), 32'd1);
            chk("to_nopulse", 32'(timeout), 32'd0);
        end
        tick();
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_release", 32'(grant_valid), 32'd0);
        tick();
        chk("to_regrant", 32'(grant_valid), 32'd1);
        chk("to_regrant_idx", 32'(grant_idx), 32'd4);
        chk("to_single", 32'(timeout), 32'd0);

        // Request drop releases without a timeout.
        req = 16'h0080;
        tick();
        chk("drop4_to", 32'(timeout), 32'd0);
        tick();
        chk("drop_idx7", 32'(grant_idx), 32'd7);
        tick();
        req = 16'h0000;
        tick();
        chk("drop_release", 32'(grant_valid), 32'd0);
        chk("drop_to", 32'(timeout), 32'd0);

        // done on the final hold cycle wins over the counter.
        req = 16'h0080;
        tick();
        chk("prec_idx7", 32'(grant_idx), 32'd7);
        for (int i = 1; i < MAX_HOLD; i++) tick();
        done = 1'b1;
        tick();
        chk("prec_release", 32'(grant_valid), 32'd0);
        chk("prec_to", 32'(timeout), 32'd0);
        done = 1'b0;

        // Reset in the middle of a grant clears the pointer.
        req = 16'h0200;
        tick();
        chk("mid_idx9", 32'(grant_idx), 32'd9);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_valid", 32'(grant_valid), 32'd0);
        chk("mid_to", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        req   = 16'h0201;
        tick();
        chk("mid_regrant0", 32'(grant_idx), 32'd0);

        // done while idle has no effect.
        req  = 16'h0000;
        done = 1'b1;
        tick();
        tick();
        tick();
        chk("idle_done", 32'(grant_valid), 32'd0);
        done = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 16'($urandom);
                    1: req = 16'(1 << $urandom_range(0, N - 1));
                    2: req = 16'h0000;
                    default: req = 16'hFFFF;
                endcase
            end
            done = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
